// File: rtl/sr_pkg.sv
// Shared definitions for the serial-in, parallel-out shift register.
// The default width and the matching parallel word type live here.
`timescale 1ns/1ps
package sr_pkg;

    localparam int SR_DEFAULT_WIDTH = 8;

    typedef logic [SR_DEFAULT_WIDTH:1] sr_word_t;

endpackage : sr_pkg

// File: rtl/sipo_stage.sv
// One stage of the shift register: a D flip-flop with an asynchronous,
// active-low clear that loads this stage's own reset bit.
`timescale 1ns/1ps
module sipo_stage #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= RST_BIT;
        end else begin
            bit_q <= d_i;
        end
    end

    assign q_o = bit_q;

endmodule : sipo_stage

// File: rtl/sr_sipo_8bit.sv
// Serial-in, parallel-out shift register: q[1] holds the newest bit, q[WIDTH]
// the oldest. Every output bit comes straight from a stage flip-flop.
`timescale 1ns/1ps
module sr_sipo_8bit
    import sr_pkg::*;
#(
    parameter int               WIDTH     = SR_DEFAULT_WIDTH,
    parameter logic [WIDTH:1]   RESET_VAL = '0
) (
    input  logic             inp,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH:1]   q
);

    // chain_d[0] is the serial input; chain_d[k] is the output of stage k.
    logic [WIDTH:0] chain_d;

    assign chain_d[0] = inp;

    for (genvar k = 1; k <= WIDTH; k++) begin : g_stage
        sipo_stage #(
            .RST_BIT (RESET_VAL[k])
        ) u_stage (
            .clk   (clk),
            .rst_n (reset),
            .d_i   (chain_d[k-1]),
            .q_o   (chain_d[k])
        );
    end

    assign q = chain_d[WIDTH:1];

endmodule : sr_sipo_8bit

// File: tb/tb_sr_sipo_8bit.sv
// Directed bench for sr_sipo_8bit: a vector table of reset/serial-bit steps
// with hand-computed parallel words, plus timing-sensitive reset sequences.
`timescale 1ns/1ps
module tb_sr_sipo_8bit;

    logic       clk;
    logic       reset;
    logic       inp;
    logic [8:1] q;
    logic [1:1] q1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst_n;
        logic       din;
        logic [8:1] exp_q;
    } vec_t;

    vec_t vecs[$];

    sr_sipo_8bit dut (
        .inp   (inp),
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    sr_sipo_8bit #(.WIDTH(1)) dut_w1 (
        .inp   (inp),
        .clk   (clk),
        .reset (reset),
        .q     (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check8(input string name, input logic [8:1] exp);
        n_vec++;
        if (q !== exp) begin
            n_err++;
            $display("FAIL %s: q got %b required %b at %0t", name, q, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic exp);
        n_vec++;
        if (q1[1] !== exp) begin
            n_err++;
            $display("FAIL %s: width-1 q got %b required %b at %0t", name, q1[1], exp, $time);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic r, input logic d);
        @(negedge clk);
        reset = r;
        inp   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // walking one
        vecs.push_back('{1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b1, 1'b1, 8'b00000001});
        vecs.push_back('{1'b1, 1'b0, 8'b00000010});
        vecs.push_back('{1'b1, 1'b0, 8'b00000100});
        vecs.push_back('{1'b1, 1'b0, 8'b00001000});
        vecs.push_back('{1'b1, 1'b0, 8'b00010000});
        vecs.push_back('{1'b1, 1'b0, 8'b00100000});
        vecs.push_back('{1'b1, 1'b0, 8'b01000000});
        vecs.push_back('{1'b1, 1'b0, 8'b10000000});
        vecs.push_back('{1'b1, 1'b0, 8'b00000000});
        // full-word load 1,0,1,1,0,0,1,0 then one extra 1
        vecs.push_back('{1'b0, 1'b0, 8'b00000000});
        vecs.push_back('{1'b1, 1'b1, 8'b00000001});
        vecs.push_back('{1'b1, 1'b0, 8'b00000010});
        vecs.push_back('{1'b1, 1'b1, 8'b00000101});
        vecs.push_back('{1'b1, 1'b1, 8'b00001011});
        vecs.push_back('{1'b1, 1'b0, 8'b00010110});
        vecs.push_back('{1'b1, 1'b0, 8'b00101100});
        vecs.push_back('{1'b1, 1'b1, 8'b01011001});
        vecs.push_back('{1'b1, 1'b0, 8'b10110010});
        vecs.push_back('{1'b1, 1'b1, 8'b01100101});
        // alternating stream starting at 1, newest bit 0 ends in q[1]
        vecs.push_back('{1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b1, 1'b1, 8'b00000001});
        vecs.push_back('{1'b1, 1'b0, 8'b00000010});
        vecs.push_back('{1'b1, 1'b1, 8'b00000101});
        vecs.push_back('{1'b1, 1'b0, 8'b00001010});
        vecs.push_back('{1'b1, 1'b1, 8'b00010101});
        vecs.push_back('{1'b1, 1'b0, 8'b00101010});
        vecs.push_back('{1'b1, 1'b1, 8'b01010101});
        vecs.push_back('{1'b1, 1'b0, 8'b10101010});

        reset = 1'b0;
        inp   = 1'b0;
        #1;
        check8("reset_at_start", 8'h00);
        check1("reset_at_start_w1", 1'b0);

        // reset held for 10 periods while inp toggles
        for (int i = 0; i < 10; i++) begin
            step(1'b0, logic'(i % 2 == 0));
            check8("reset_held", 8'h00);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].din);
            check8($sformatf("vec%0d", i), vecs[i].exp_q);
            check1($sformatf("vec%0d_w1", i), vecs[i].rst_n ? vecs[i].din : 1'b0);
        end

        // async reset mid-period from an all-ones word
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        check8("load_ones", 8'hFF);
        #3;
        reset = 1'b0;
        #0.5;
        check8("async_clear", 8'h00);
        check1("async_clear_w1", 1'b0);

        // release 1 ns before a rising edge with inp=1
        @(posedge clk);
        #9;
        reset = 1'b1;
        inp   = 1'b1;
        #0.5;
        check8("release_before_edge", 8'h00);
        @(posedge clk);
        #1;
        check8("release_first_shift", 8'b00000001);
        check1("release_first_shift_w1", 1'b1);
        @(negedge clk);
        inp = 1'b0;
        @(posedge clk);
        #1;
        check8("release_second_shift", 8'b00000010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sr_sipo_8bit
